// File: rtl/blast_window_feeder.sv
// rtl/blast_window_feeder.sv - sliding 11-base DB window feeder for the BLAST comparator
// Optional window/stall counters are built when BLAST_FEEDER_STATS_EN is defined.
module blast_window_feeder #(
  parameter int WORD_BASES = 16,
  parameter int WIN_BASES  = 11,
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*WIN_BASES-1:0]  query_in,
  input  logic                    query_load,
  input  logic                    start,
  input  logic [2*WORD_BASES-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [2*WIN_BASES-1:0]  outQuery,
  output logic [2*WIN_BASES-1:0]  outDB,
  output logic [POS_W-1:0]        out_pos,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    done
`ifdef BLAST_FEEDER_STATS_EN
  ,
  output logic [31:0]             win_count,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int BUF_BASES = WIN_BASES - 1 + WORD_BASES;
  localparam int BUF_W     = 2 * BUF_BASES;
  localparam int WIN_W     = 2 * WIN_BASES;
  localparam int WORD_W    = 2 * WORD_BASES;
  localparam int FILL_W    = $clog2(BUF_BASES + 1);
  localparam logic [FILL_W-1:0] WIN_F  = FILL_W'(WIN_BASES);
  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_BASES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [BUF_W-1:0]  base_buf, bases_nx, shifted, word_ext;
  logic [FILL_W-1:0] fill, fill_nx, kept;
  logic              last_seen, emit, accept;

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    s_ready   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        out_valid = (fill >= WIN_F);
        out_last  = out_valid && last_seen && (fill == WIN_F);
        // A word may land on a full window only if that window leaves this cycle.
        s_ready   = !last_seen && ((fill < WIN_F) || ((fill == WIN_F) && out_ready));
        if (out_valid && out_ready && out_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign emit     = out_valid && out_ready;
  assign accept   = s_valid && s_ready;
  assign kept     = fill - {{(FILL_W-1){1'b0}}, emit};
  assign shifted  = emit ? {base_buf[BUF_W-3:0], 2'b00} : base_buf;
  assign word_ext = {s_data, {(BUF_W-WORD_W){1'b0}}};
  // Bits past fill are always zero, so the new word can be OR-ed in behind the kept bases.
  assign bases_nx = accept ? (shifted | (word_ext >> {kept, 1'b0})) : shifted;
  assign fill_nx  = accept ? (kept + WORD_F) : kept;
  assign outDB    = base_buf[BUF_W-1 -: WIN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_buf  <= '0;
      fill      <= '0;
      out_pos   <= '0;
      last_seen <= 1'b0;
      outQuery  <= '0;
    end else if (state == IDLE) begin
      if (query_load) outQuery <= query_in;
      if (start) begin
        base_buf  <= '0;
        fill      <= '0;
        out_pos   <= '0;
        last_seen <= 1'b0;
      end
    end else if (state == RUN) begin
      base_buf <= bases_nx;
      fill     <= fill_nx;
      if (emit) out_pos <= out_pos + POS_W'(1);
      if (accept && s_last) last_seen <= 1'b1;
    end
  end

`ifdef BLAST_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count    <= '0;
      stall_cycles <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        win_count    <= '0;
        stall_cycles <= '0;
      end
    end else if (state == RUN) begin
      if (emit && (win_count != '1)) win_count <= win_count + 32'd1;
      if (out_valid && !out_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blast_window_feeder.sv
// tb/tb_blast_window_feeder.sv - self-checking bench for blast_window_feeder
// Base-queue model checked every cycle plus directed literal expectations.
module tb_blast_window_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] query_in;
  logic        query_load, start;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [21:0] outQuery, outDB;
  logic [31:0] out_pos;
  logic        out_valid, out_last, out_ready, done;
`ifdef BLAST_FEEDER_STATS_EN
  logic [31:0] win_count, stall_cycles;
`endif

  always #5 clk = ~clk;

  blast_window_feeder dut (
    .clk(clk), .rst(rst), .query_in(query_in), .query_load(query_load), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .outQuery(outQuery), .outDB(outDB), .out_pos(out_pos), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .done(done)
`ifdef BLAST_FEEDER_STATS_EN
    , .win_count(win_count), .stall_cycles(stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted base in order; window e is bases e..e+10.
  logic [1:0]  mb[$];
  int          ne, avail, stall_m;
  bit          in_pass, last_acc, done_flag, idle;
  bit          exp_valid, exp_last, exp_ready;
  logic [21:0] mq, exp_db;

  int tnum = 0, prev_t = -1, cyc = 0;
  int t_win, t_last, t_lastpos, t_stall, t_done, first_emit, last_emit, done_cyc, first_pos;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mb.delete(); ne = 0; in_pass = 0; last_acc = 0; done_flag = 0; mq = '0; stall_m = 0;
      end
      avail     = mb.size() - ne;
      exp_valid = in_pass && (avail >= 11);
      exp_last  = exp_valid && last_acc && (avail == 11);
      exp_ready = in_pass && !last_acc && ((avail <= 10) || ((avail == 11) && out_ready));
      exp_db    = '0;
      if (exp_valid)
        for (int j = 0; j < 11; j++) exp_db = {exp_db[19:0], mb[ne+j]};

      chk("s_ready", s_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("done", done, done_flag);
      chk("outQuery", outQuery, mq);
      chk("out_pos", out_pos, 32'(ne));
      if (exp_valid) begin
        chk("outDB", outDB, exp_db);
        chk("out_last", out_last, exp_last);
      end
      if (rst) begin
        chk("rst_outDB", outDB, 22'h0);
        chk("rst_out_last", out_last, 1'b0);
      end
`ifdef BLAST_FEEDER_STATS_EN
      chk("win_count", win_count, 32'(ne));
      chk("stall_cycles", stall_cycles, 32'(stall_m));
`endif

      if (tnum != prev_t) begin
        prev_t = tnum; t_win = 0; t_last = 0; t_lastpos = -1; t_stall = 0; t_done = 0;
        first_emit = -1; last_emit = -1; done_cyc = -1; first_pos = -1;
      end
      if (out_valid && out_ready) begin
        if (t_win == 0) begin first_emit = cyc; first_pos = int'(out_pos); end
        last_emit = cyc;
        t_win++;
        if (out_last) begin t_last++; t_lastpos = int'(out_pos); end
      end
      if (out_valid && !out_ready) t_stall++;
      if (done) begin t_done++; done_cyc = cyc; end

      if (tnum == 1 && out_valid) begin
        chk("t1_db", outDB, 22'h0);
        chk("t1_last", out_last, out_pos == 32'd5);
      end
      if (tnum == 2 && out_valid) begin
        if (out_pos == 32'd5) chk("t2_pos5", outDB, 22'h155555);
        if (out_pos == 32'd6) chk("t2_pos6", outDB, 22'h155557);
        if (out_pos >= 32'd16 && out_pos <= 32'd21) chk("t2_ones", outDB, 22'h3FFFFF);
        chk("t2_last", out_last, out_pos == 32'd21);
      end
      if (tnum == 4 && out_valid && !out_ready) begin
        chk("t4_hold_db", outDB, 22'h31B1B1);
        chk("t4_hold_pos", out_pos, 32'd3);
      end

      if (!rst) begin
        idle = !in_pass && !done_flag;
        if (done_flag) done_flag = 0;
        if (in_pass) begin
          if (exp_valid && !out_ready) stall_m++;
          if (s_valid && exp_ready) begin
            for (int b = 0; b < 16; b++) mb.push_back(s_data[31-2*b -: 2]);
            if (s_last) last_acc = 1;
          end
          if (exp_valid && out_ready) begin
            ne++;
            if (exp_last) begin in_pass = 0; done_flag = 1; end
          end
        end else if (idle) begin
          if (query_load) mq = query_in;
          if (start) begin in_pass = 1; mb.delete(); ne = 0; last_acc = 0; stall_m = 0; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass(input logic [21:0] q);
    query_in = q; query_load = 1; start = 1;
    tick();
    query_load = 0; start = 0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    bit seen = 0;
    s_data = w; s_valid = 1; s_last = last;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = s_ready;
    end
    chk("word_accepted", s_ready, 1'b1);
    tick();
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", done, 1'b1);
    tick();
  endtask

  task automatic wait_pos(input logic [31:0] p);
    for (int k = 0; k < 100 && out_pos != p; k++) tick();
    chk("pos_reached", out_pos, p);
  endtask

  initial begin : driver
    rst = 1; query_in = '0; query_load = 0; start = 0;
    s_data = '0; s_valid = 0; s_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pos", out_pos, 32'd0);
    rst = 0;
    tick();

    tnum = 1;
    begin_pass(22'h0);
    send(32'h00000000, 1);
    wait_done();
    chk("t1_windows", t_win, 6);
    chk("t1_last_cnt", t_last, 1);
    chk("t1_last_pos", t_lastpos, 5);
    chk("t1_done_cnt", t_done, 1);
    chk("t1_done_next", done_cyc, last_emit + 1);

    tnum = 2;
    begin_pass(22'h1);
    send(32'h55555555, 0);
    send(32'hFFFFFFFF, 1);
    wait_done();
    chk("t2_windows", t_win, 22);
    chk("t2_last_pos", t_lastpos, 21);

    tnum = 3;
    begin_pass(22'h3FFFFF);
    send(32'hDEADBEEF, 0);
    send(32'h01234567, 0);
    send(32'h89ABCDEF, 1);
    wait_done();
    chk("t3_windows", t_win, 38);
    chk("t3_span", last_emit - first_emit, 37);
    chk("t3_no_stall", t_stall, 0);

    tnum = 4;
    begin_pass(22'h2AAAAA);
    send(32'h1B1B1B1B, 1);
    wait_pos(32'd3);
    out_ready = 0;
    repeat (5) tick();
    out_ready = 1;
    wait_done();
    chk("t4_windows", t_win, 6);
    chk("t4_stalls", t_stall, 5);
`ifdef BLAST_FEEDER_STATS_EN
    chk("t4_stat_stall", stall_cycles, 32'd5);
    chk("t4_stat_win", win_count, 32'd6);
`endif

    tnum = 5;
    begin_pass(22'h3FFFFF);
    send(32'hFFFF0000, 0);
    send(32'h12345678, 0);
    wait_pos(32'd7);
    rst = 1;
    #1;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_pos", out_pos, 32'd0);
    chk("t5_query", outQuery, 22'h0);
    chk("t5_db", outDB, 22'h0);
    chk("t5_ready", s_ready, 1'b0);
    tick();
    rst = 0;
    tick();
    tnum = 51;
    begin_pass(22'h0);
    send(32'hCAFEF00D, 1);
    wait_done();
    chk("t5_windows", t_win, 6);
    chk("t5_first_pos", first_pos, 0);
    chk("t5_last_pos", t_lastpos, 5);

    tnum = 6;
    begin_pass(22'h0F0F0F);
    chk("t6_q_loaded", outQuery, 22'h0F0F0F);
    query_in = 22'h2AAAAA; query_load = 1; start = 1;
    tick();
    query_load = 0; start = 0;
    chk("t6_q_run", outQuery, 22'h0F0F0F);
    send(32'hE4E4E4E4, 1);
    wait_done();
    chk("t6_windows", t_win, 6);
    query_in = 22'h155555; query_load = 1;
    tick();
    query_load = 0;
    chk("t6_q_idle", outQuery, 22'h155555);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
